// File: rtl/mult_pkg.sv
// Shared definitions for the shift-and-add multiplier: FSM state encoding and counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 4;

  // Step counter must hold the value WIDTH itself
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/ripple_adder.sv
// WIDTH-bit ripple-carry adder with carry-in and carry-out, built bit by bit.
module ripple_adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // One full-adder cell per bit, carry rippling upward
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign sum[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign cout = carry[WIDTH];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Sequential unsigned shift-and-add multiplier: one conditional add-and-shift per clock,
// 2*WIDTH-bit product with a one-cycle done strobe.
// Optional build macro MULT_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
module shift_add_mult_ctrl
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] m_reg;
  // The carry of each add is shifted straight into the top of acc, so acc never
  // needs to keep a separate carry bit between steps (it would always be zero).
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] q_reg;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0]   addend_c;
  logic [WIDTH-1:0]   add_sum_c;
  logic               add_cout_c;
  logic [WIDTH-1:0]   acc_nxt_c;
  logic [WIDTH-1:0]   q_nxt_c;
  logic               finish_c;
  logic [2*WIDTH-1:0] prod_c;

  // Conditional addend: multiplicand when the current multiplier bit is set
  assign addend_c = q_reg[0] ? m_reg : '0;

  ripple_adder #(
    .WIDTH (WIDTH)
  ) u_add (
    .a    (acc),
    .b    (addend_c),
    .cin  (1'b0),
    .sum  (add_sum_c),
    .cout (add_cout_c)
  );

  // {carry,sum,Q} shifted right by one: carry enters acc MSB, sum LSB enters Q MSB
  assign acc_nxt_c = {add_cout_c, add_sum_c[WIDTH-1:1]};
  assign q_nxt_c   = {add_sum_c[0], q_reg[WIDTH-1:1]};

`ifdef MULT_EARLY_TERM_EN
  logic [CW-1:0]      rem_c;
  logic [WIDTH-1:0]   rem_mask_c;
  logic [2*WIDTH-1:0] pp_c;

  // Remaining multiplier bits after this step sit in the low rem_c bits of Q
  assign rem_c      = cnt - CW'(1);
  assign rem_mask_c = ~({WIDTH{1'b1}} << rem_c);
  assign pp_c       = {acc_nxt_c, q_nxt_c};
  assign finish_c   = ((q_nxt_c & rem_mask_c) == '0);
  // Skipped steps would only shift zeros in, so a barrel shift completes them at once
  assign prod_c     = pp_c >> rem_c;
`else
  // Fixed-latency finish on the last of WIDTH steps
  assign finish_c = (cnt == CW'(1));
  assign prod_c   = {acc_nxt_c, q_nxt_c};
`endif

  // Sequencer, operand registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      m_reg   <= '0;
      acc     <= '0;
      q_reg   <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            m_reg <= a;
            acc   <= '0;
            q_reg <= b;
            cnt   <= CW'(WIDTH);
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= acc_nxt_c;
          q_reg <= q_nxt_c;
          cnt   <= cnt - CW'(1);
          if (finish_c) begin
            product <= prod_c;
            done    <= 1'b1;
            state   <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl at WIDTH=4: directed cases plus a
// shuffled exhaustive sweep, checked against a*b and the expected latency.
module tb_shift_add_mult_ctrl;

  localparam int unsigned W = 4;
`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int n_cmp;
  int n_err;

  shift_add_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Latency in cycles from start acceptance to done, from the operand rules alone
  function automatic int exp_latency(input logic [W-1:0] bv);
    int h;
    if (!EARLY) return W + 1;
    if (bv == '0) return 2;
    h = 0;
    for (int i = 0; i < W; i++) if (bv[i]) h = i;
    return h + 2;
  endfunction

  // Issue one multiply; optionally hold a junk start request during RUN and DONE
  task automatic run_mult(input logic [W-1:0] av, input logic [W-1:0] bv, input bit junk);
    int  edges;
    bit  seen;
    logic [2*W-1:0] exp_p;
    exp_p = (2*W)'(av) * (2*W)'(bv);
    start = 1'b1;
    a     = av;
    b     = bv;
    @(posedge clk);
    #1;
    if (junk) begin
      a = 4'd7;
      b = 4'd7;
    end else begin
      start = 1'b0;
      a     = W'($urandom);
      b     = W'($urandom);
    end
    check("busy_after_accept", 32'(busy), 32'd1);
    edges = 0;
    seen  = 1'b0;
    while (edges < 20 && !seen) begin
      @(posedge clk);
      #1;
      edges++;
      if (done) seen = 1'b1;
      else if (!busy) begin
        check("busy_during_op", 32'(busy), 32'd1);
        edges = 20;
      end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("latency", 32'(edges + 1), 32'(exp_latency(bv)));
      check("product", 32'(product), 32'(exp_p));
      @(posedge clk);
      #1;
      start = 1'b0;
      check("done_one_cycle", 32'(done), 32'd0);
      check("busy_fall", 32'(busy), 32'd0);
    end
  endtask

  logic [7:0] pairs [256];
  logic [7:0] tmp;
  int         j;
  int         extra_done;

  initial begin
    n_cmp = 0;
    n_err = 0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    rst_n = 1'b0;
    #3;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_done", 32'(done), 32'd0);
    check("reset_product", 32'(product), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed cases
    run_mult(4'b1010, 4'b1011, 1'b0);
    run_mult(4'hF, 4'hF, 1'b0);
    run_mult(4'h9, 4'h0, 1'b0);

    // Requests during RUN and DONE are ignored
    run_mult(4'd3, 4'd5, 1'b1);
    extra_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) extra_done++;
    end
    check("ignored_start_no_done", 32'(extra_done), 32'd0);
    check("ignored_start_product", 32'(product), 32'h0F);
    check("ignored_start_idle", 32'(busy), 32'd0);

    // Asynchronous reset in the middle of RUN
    start = 1'b1;
    a     = 4'd6;
    b     = 4'd7;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_done", 32'(done), 32'd0);
    check("async_rst_product", 32'(product), 32'd0);
    @(posedge clk);
    #1;
    check("rst_held_product", 32'(product), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_mult(4'd2, 4'd3, 1'b0);

    // Exhaustive operand space in shuffled order, back-to-back at minimum spacing
    for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
    for (int i = 255; i > 0; i--) begin
      j        = int'($urandom_range(i, 0));
      tmp      = pairs[i];
      pairs[i] = pairs[j];
      pairs[j] = tmp;
    end
    for (int i = 0; i < 256; i++) begin
      tmp = pairs[i];
      run_mult(tmp[7:4], tmp[3:0], 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
